// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and constants for the parametrised register file
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // Geometry of the original CPU register file
    localparam int CPU_WIDTH = 8;
    localparam int CPU_DEPTH = 8;

endpackage

// File: rtl/reg_file_sweep_ctrl.sv
// rtl/reg_file_sweep_ctrl.sv - clear-sweep FSM, write acceptance and drop pulse
module reg_file_sweep_ctrl
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = CPU_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITEEN,
    input  logic [ADDR_W-1:0] INADDR,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              wr_accept,
    output logic              WR_DROP
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    sweep_state_t      state;
    logic [ADDR_W-1:0] cnt;
    logic              zero_hit;
    logic              in_range;
    logic              can_write;
    logic              wr_reject;

    assign zero_hit  = ZERO_REG && (INADDR == '0);
    assign in_range  = {1'b0, INADDR} < DEPTH_X;
    assign can_write = (state == IDLE) && !CLEAR && in_range;
    assign wr_accept = WRITEEN && can_write && !zero_hit;
    // Writes to a hard-wired zero register vanish quietly instead of flagging a drop
    assign wr_reject = WRITEEN && !can_write && !zero_hit;

    assign BUSY       = (state == SWEEP);
    assign sweep_en   = (state == SWEEP);
    assign sweep_addr = cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            WR_DROP <= 1'b0;
        end else begin
            WR_DROP <= wr_reject;
            case (state)
                IDLE: begin
                    if (CLEAR) begin
                        state <= SWEEP;
                        cnt   <= '0;
                    end
                end
                SWEEP: begin
                    if (cnt == LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with bypass, valid bits and clear sweep
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = CPU_WIDTH,
    parameter int DEPTH    = CPU_DEPTH,
    localparam int ADDR_W  = $clog2(DEPTH),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WIDTH-1:0]  IN,
    input  logic [ADDR_W-1:0] INADDR,
    input  logic              WRITEEN,
    input  logic [ADDR_W-1:0] OUT1ADD,
    input  logic [ADDR_W-1:0] OUT2ADD,
    output logic [WIDTH-1:0]  OUT1,
    output logic [WIDTH-1:0]  OUT2,
    output logic              OUT1_VALID,
    output logic              OUT2_VALID,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              WR_DROP
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]           mem [DEPTH];
    logic [DEPTH-1:0]           valid;
    logic                       sweep_en;
    logic [ADDR_W-1:0]          sweep_addr;
    logic                       wr_accept;
    logic [1:0][ADDR_W-1:0]     raddr;
    logic [1:0][WIDTH:0]        rd;

    reg_file_sweep_ctrl #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sweep_ctrl (
        .CLK        (CLK),
        .RESET      (RESET),
        .WRITEEN    (WRITEEN),
        .INADDR     (INADDR),
        .CLEAR      (CLEAR),
        .BUSY       (BUSY),
        .sweep_en   (sweep_en),
        .sweep_addr (sweep_addr),
        .wr_accept  (wr_accept),
        .WR_DROP    (WR_DROP)
    );

    // Sweep and write never coincide: writes are only accepted in IDLE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid <= '0;
        end else if (sweep_en) begin
            mem[sweep_addr]   <= '0;
            valid[sweep_addr] <= 1'b0;
        end else if (wr_accept) begin
            mem[INADDR]   <= IN;
            valid[INADDR] <= 1'b1;
        end
    end

    assign raddr = {OUT2ADD, OUT1ADD};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rd[p] = (ZERO_REG && raddr[p] == '0)                 ? {1'b1, {WIDTH{1'b0}}} :
                       (BYPASS && wr_accept && INADDR == raddr[p])   ? {1'b1, IN} :
                       ({1'b0, raddr[p]} < DEPTH_X)                  ? {valid[raddr[p]], mem[raddr[p]]} :
                                                                       {(WIDTH + 1){1'b0}};
    end

    assign {OUT1_VALID, OUT1} = rd[0];
    assign {OUT2_VALID, OUT2} = rd[1];

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for three configurations of reg_file_param
module tb_reg_file_param;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] IN;
    logic [2:0] INADDR, OUT1ADD, OUT2ADD;
    logic       WRITEEN, CLEAR;

    logic [7:0] o1 [3];
    logic [7:0] o2 [3];
    logic       v1 [3];
    logic       v2 [3];
    logic       busy [3];
    logic       drop [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    // a: default (bypass), b: no bypass, c: zero register with depth 6
    reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDR(INADDR), .WRITEEN(WRITEEN),
        .OUT1ADD(OUT1ADD), .OUT2ADD(OUT2ADD), .OUT1(o1[0]), .OUT2(o2[0]),
        .OUT1_VALID(v1[0]), .OUT2_VALID(v2[0]), .CLEAR(CLEAR), .BUSY(busy[0]), .WR_DROP(drop[0]));

    reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDR(INADDR), .WRITEEN(WRITEEN),
        .OUT1ADD(OUT1ADD), .OUT2ADD(OUT2ADD), .OUT1(o1[1]), .OUT2(o2[1]),
        .OUT1_VALID(v1[1]), .OUT2_VALID(v2[1]), .CLEAR(CLEAR), .BUSY(busy[1]), .WR_DROP(drop[1]));

    reg_file_param #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
        .CLK(CLK), .RESET(RESET), .IN(IN), .INADDR(INADDR), .WRITEEN(WRITEEN),
        .OUT1ADD(OUT1ADD), .OUT2ADD(OUT2ADD), .OUT1(o1[2]), .OUT2(o2[2]),
        .OUT1_VALID(v1[2]), .OUT2_VALID(v2[2]), .CLEAR(CLEAR), .BUSY(busy[2]), .WR_DROP(drop[2]));

    // Behavioural model of each configuration
    logic [7:0] md [3][8];
    logic       mv [3][8];
    logic       msw [3];
    int         mpos [3];
    logic       mdrop [3];

    function automatic int dep(input int c);
        return (c == 2) ? 6 : 8;
    endfunction

    function automatic logic zro(input int c);
        return c == 2;
    endfunction

    function automatic logic byp(input int c);
        return c != 1;
    endfunction

    function automatic logic m_accept(input int c);
        return !msw[c] && !CLEAR && WRITEEN && (int'(INADDR) < dep(c)) && !(zro(c) && INADDR == 3'd0);
    endfunction

    function automatic logic [8:0] m_read(input int c, input logic [2:0] a);
        if (zro(c) && a == 3'd0) return {1'b1, 8'h00};
        if (byp(c) && m_accept(c) && INADDR == a) return {1'b1, IN};
        if (int'(a) >= dep(c)) return 9'h000;
        return {mv[c][a], md[c][a]};
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int c = 0; c < 3; c++) begin
                for (int i = 0; i < 8; i++) begin
                    md[c][i] = 8'h00;
                    mv[c][i] = 1'b0;
                end
                msw[c]   = 1'b0;
                mpos[c]  = 0;
                mdrop[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                logic acc;
                acc      = m_accept(c);
                mdrop[c] = WRITEEN && !acc && !(zro(c) && INADDR == 3'd0);
                if (msw[c]) begin
                    md[c][mpos[c]] = 8'h00;
                    mv[c][mpos[c]] = 1'b0;
                    mpos[c]++;
                    if (mpos[c] == dep(c)) msw[c] = 1'b0;
                end else if (CLEAR) begin
                    msw[c]  = 1'b1;
                    mpos[c] = 0;
                end else if (acc) begin
                    md[c][INADDR] = IN;
                    mv[c][INADDR] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("c%0d port1", c), 32'({v1[c], o1[c]}), 32'(m_read(c, OUT1ADD)));
            chk($sformatf("c%0d port2", c), 32'({v2[c], o2[c]}), 32'(m_read(c, OUT2ADD)));
            chk($sformatf("c%0d busy", c), 32'(busy[c]), 32'(msw[c]));
            chk($sformatf("c%0d wr_drop", c), 32'(drop[c]), 32'(mdrop[c]));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int busy_cnt;
        int drop_cnt;
        RESET = 1'b0; IN = 8'h00; INADDR = 3'd0; WRITEEN = 1'b0; CLEAR = 1'b0;
        OUT1ADD = 3'd0; OUT2ADD = 3'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset out1", 32'({v1[0], o1[0]}), 32'h000);
        chk("reset busy", 32'(busy[0]), 32'h0);
        tick();
        RESET = 1'b1;

        // basic write then read
        WRITEEN = 1'b1; INADDR = 3'd3; IN = 8'hA5;
        tick();
        WRITEEN = 1'b0; OUT1ADD = 3'd3; OUT2ADD = 3'd4;
        @(negedge CLK);
        chk("r3 read", 32'({v1[0], o1[0]}), 32'h1A5);
        chk("r4 unwritten", 32'({v2[0], o2[0]}), 32'h000);

        // same-cycle bypass versus no bypass
        tick();
        WRITEEN = 1'b1; INADDR = 3'd5; IN = 8'h3C; OUT1ADD = 3'd5; OUT2ADD = 3'd5;
        @(negedge CLK);
        chk("bypass port1", 32'({v1[0], o1[0]}), 32'h13C);
        chk("bypass port2", 32'({v2[0], o2[0]}), 32'h13C);
        chk("no bypass before edge", 32'({v1[1], o1[1]}), 32'h000);
        tick();
        WRITEEN = 1'b0;
        @(negedge CLK);
        chk("no bypass after edge", 32'({v1[1], o1[1]}), 32'h13C);

        // fill, then sweep
        for (int i = 0; i < 8; i++) begin
            tick();
            WRITEEN = 1'b1; INADDR = 3'(i); IN = 8'h10 + 8'(i);
        end
        tick();
        WRITEEN = 1'b0; CLEAR = 1'b1; OUT1ADD = 3'd2; OUT2ADD = 3'd6;
        tick();
        CLEAR = 1'b0;
        busy_cnt = 0;
        drop_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge CLK);
            if (busy[0]) busy_cnt++;
            if (drop[0]) drop_cnt++;
            if (j == 2) chk("r2 before its sweep edge", 32'({v1[0], o1[0]}), 32'h112);
            if (j == 3) begin
                chk("r2 swept", 32'({v1[0], o1[0]}), 32'h000);
                chk("r6 kept", 32'({v2[0], o2[0]}), 32'h116);
            end
            if (j == 8) chk("write after sweep", 32'({v1[0], o1[0]}), 32'h144);
            @(posedge CLK);
            #1;
            if (j == 3) begin WRITEEN = 1'b1; INADDR = 3'd1; IN = 8'h77; end
            if (j == 4) WRITEEN = 1'b0;
            if (j == 7) begin WRITEEN = 1'b1; INADDR = 3'd4; IN = 8'h44; OUT1ADD = 3'd4; end
            if (j == 8) WRITEEN = 1'b0;
        end
        chk("busy cycles", 32'(busy_cnt), 32'd8);
        chk("drop pulses", 32'(drop_cnt), 32'd1);

        // clear wins over a same-cycle write
        tick();
        CLEAR = 1'b1; WRITEEN = 1'b1; INADDR = 3'd1; IN = 8'h11;
        tick();
        CLEAR = 1'b0; WRITEEN = 1'b0; OUT1ADD = 3'd1;
        @(negedge CLK);
        chk("clear+write drop", 32'(drop[0]), 32'h1);
        repeat (9) tick();
        @(negedge CLK);
        chk("r1 after sweep", 32'({v1[0], o1[0]}), 32'h000);
        chk("idle after sweep", 32'(busy[0]), 32'h0);

        // zero register and out-of-range addresses
        tick();
        WRITEEN = 1'b1; INADDR = 3'd0; IN = 8'hFF; OUT1ADD = 3'd0; OUT2ADD = 3'd6;
        tick();
        INADDR = 3'd7; IN = 8'h5A;
        @(negedge CLK);
        chk("zero reg read", 32'({v1[2], o1[2]}), 32'h100);
        chk("zero reg no drop", 32'(drop[2]), 32'h0);
        chk("addr 6 out of range", 32'({v2[2], o2[2]}), 32'h000);
        tick();
        WRITEEN = 1'b0;
        @(negedge CLK);
        chk("addr 7 drop", 32'(drop[2]), 32'h1);

        // reset in the middle of a sweep
        tick();
        WRITEEN = 1'b1; INADDR = 3'd7; IN = 8'h77;
        tick();
        WRITEEN = 1'b0; CLEAR = 1'b1; OUT1ADD = 3'd7;
        tick();
        CLEAR = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        chk("reset aborts busy", 32'(busy[0]), 32'h0);
        chk("reset clears r7", 32'({v1[0], o1[0]}), 32'h000);
        tick();
        RESET = 1'b1; WRITEEN = 1'b1; INADDR = 3'd2; IN = 8'h22; OUT1ADD = 3'd2;
        tick();
        WRITEEN = 1'b0;
        @(negedge CLK);
        chk("write after reset", 32'({v1[0], o1[0]}), 32'h122);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
